alu_cmd_issuer: RTL and testbench

Command-side master for the registered 32-bit ALU. It accepts an operation request over a valid/ready interface and decodes a compact 3-bit opcode into the 6-bit ALUFN encoding. It drives the ALU operand and function inputs, waits out the ALU's registered latency, captures the ALU result and returns it over a valid/ready response interface. It sits between the fingerprint datapath sequencers and the ALU, so no upstream block drives ALUFN directly.

---
 rtl/alu_cmd_issuer.sv | 163 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
// Command-side master for the registered ALU. It accepts one request at a
// time, decodes the 3-bit opcode into ALUFN and holds the operands steady on
// the ALU inputs. It then waits out the ALU latency, captures the result and
// returns it on a valid/ready response channel. Opcode 7 is answered at once
// with an error response and never reaches the ALU.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     request handshake; cmd_op, cmd_a, cmd_b request payload
//   alu_fn/a/b          registered ALU function and operands
//   alu_y               registered ALU result
//   rsp_valid/ready     response handshake; rsp_data, rsp_err response payload
//   op_count            successful (non-error) responses delivered, wrapping
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | ALU inputs stable, ALU samples them on this edge
// WAIT  | counting down the ALU latency
// DONE  | response presented, held until consumed
module alu_cmd_issuer #(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 1,   // 1..15
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic [5:0]           alu_fn,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_err,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Counter is loaded in ISSUE; capture happens on the edge it reads zero.
  localparam logic [3:0] WAIT_LOAD = 4'(ALU_LATENCY - 1);

  state_t                 state_q, state_d;
  logic [3:0]             wait_q, wait_d;
  logic [5:0]             fn_q, fn_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [5:0]             dec_fn;
  logic                   dec_legal;

  always_comb begin
    dec_fn    = 6'b000000;
    dec_legal = 1'b1;
    case (cmd_op)
      3'd0:    dec_fn = 6'b010000;
      3'd1:    dec_fn = 6'b010001;
      3'd2:    dec_fn = 6'b101000;
      3'd3:    dec_fn = 6'b101110;
      3'd4:    dec_fn = 6'b100110;
      3'd5:    dec_fn = 6'b101001;
      3'd6:    dec_fn = 6'b101010;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fn_d    = fn_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (dec_legal) begin
            fn_d    = dec_fn;
            a_d     = cmd_a;
            b_d     = cmd_b;
            state_d = ISSUE;
          end else begin
            // ALU inputs untouched so the datapath keeps seeing the last
            // legal command.
            data_d  = '0;
            err_d   = 1'b1;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        wait_d  = WAIT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == 4'd0) begin
          data_d  = alu_y;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (!err_q) cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
      fn_q    <= 6'b000000;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fn_q    <= fn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by rst so no request is taken while the block is held in reset.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign alu_fn    = fn_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer. Instance 0 uses the default parameters; instance 1
// uses ALU_LATENCY=3 and CNT_WIDTH=4. Each has its own small ALU model.
module tb_alu_cmd_issuer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][2:0]  cmd_op;
  logic [1:0][31:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, rsp_data;
  logic [1:0][5:0]  alu_fn;
  logic [15:0]      opc0;
  logic [3:0]       opc1;

  int n_chk = 0;
  int n_err = 0;
  bit mdl_on = 1'b0;

  alu_cmd_issuer dut0 (
    .clk(clk), .rst(rst[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
    .alu_fn(alu_fn[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_y(alu_y[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .op_count(opc0)
  );

  alu_cmd_issuer #(.ALU_LATENCY(3), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
    .alu_fn(alu_fn[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_y(alu_y[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .op_count(opc1)
  );

  // ALU behaviour keyed on ALUFN
  function automatic logic [31:0] alu_f(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      6'b010000: return a + b;
      6'b010001: return a - b;
      6'b101000: return a & b;
      6'b101110: return a | b;
      6'b100110: return a ^ b;
      6'b101001: return ~(a ^ b);
      6'b101010: return a;
      default:   return 32'h0;
    endcase
  endfunction

  logic [31:0] y0, y1a, y1b, y1c;
  always @(posedge clk) begin
    y0  <= alu_f(alu_fn[0], alu_a[0], alu_b[0]);
    y1a <= alu_f(alu_fn[1], alu_a[1], alu_b[1]);
    y1b <= y1a;
    y1c <= y1b;
  end
  assign alu_y[0] = y0;
  assign alu_y[1] = y1c;

  // Expected response of a command by opcode: {err, data}
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return {1'b0, a + b};
      3'd1:    return {1'b0, a - b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~(a ^ b)};
      3'd6:    return {1'b0, a};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic logic [5:0] fn_of(input logic [2:0] op);
    case (op)
      3'd0:    return 6'b010000;
      3'd1:    return 6'b010001;
      3'd2:    return 6'b101000;
      3'd3:    return 6'b101110;
      3'd4:    return 6'b100110;
      3'd5:    return 6'b101001;
      3'd6:    return 6'b101010;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] opc_of(input int s);
    return (s == 0) ? opc0 : {12'h0, opc1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending response per instance, op count
  logic [1:0]       pend_v = 2'b00;
  logic [1:0][32:0] pend_d;
  int               exp_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    if (mdl_on) begin
      for (int s = 0; s < 2; s++) begin
        if (rsp_valid[s]) begin
          chk("rsp_expected", 32'(pend_v[s]), 32'd1);
          if (pend_v[s]) begin
            chk("mdl_data", rsp_data[s], pend_d[s][31:0]);
            chk("mdl_err", 32'(rsp_err[s]), 32'(pend_d[s][32]));
          end
        end
        chk("mdl_op_count", 32'(opc_of(s)), exp_cnt[s] & ((s == 0) ? 32'hFFFF : 32'hF));
        if (pend_v[s]) chk("one_outstanding", 32'(cmd_ready[s]), 32'd0);
        if (rst[s]) begin
          pend_v[s]  = 1'b0;
          exp_cnt[s] = 0;
        end else if (rsp_valid[s] && rsp_ready[s] && pend_v[s]) begin
          pend_v[s] = 1'b0;
          if (!pend_d[s][32]) exp_cnt[s]++;
        end else if (cmd_valid[s] && cmd_ready[s]) begin
          pend_v[s] = 1'b1;
          pend_d[s] = model(cmd_op[s], cmd_a[s], cmd_b[s]);
        end
      end
    end
  end

  // Issue one command, check decode, latency, payload, optional backpressure.
  task automatic do_cmd(input int s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input int hold);
    logic [5:0]  fn0;
    logic [31:0] a0, b0, d0;
    int          n_exp;
    bit          got;
    fn0   = alu_fn[s];
    a0    = alu_a[s];
    b0    = alu_b[s];
    n_exp = (op == 3'd7) ? 0 : lat_of(s) + 1;
    @(posedge clk); #1;
    cmd_valid[s] = 1'b1; cmd_op[s] = op; cmd_a[s] = a; cmd_b[s] = b;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready[s]) got = 1'b1;
    end
    chk("accept", 32'(got), 32'd1);
    if (!got) begin
      cmd_valid[s] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid[s] = 1'b0;
    for (int n = 0; n <= n_exp; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("alu_fn", 32'(alu_fn[s]), 32'((op == 3'd7) ? fn0 : fn_of(op)));
        chk("alu_a", alu_a[s], (op == 3'd7) ? a0 : a);
        chk("alu_b", alu_b[s], (op == 3'd7) ? b0 : b);
      end
      if (n < n_exp) chk("rsp_early", 32'(rsp_valid[s]), 32'd0);
    end
    chk("rsp_valid_lat", 32'(rsp_valid[s]), 32'd1);
    chk("rsp_data", rsp_data[s], exp_d);
    chk("rsp_err", 32'(rsp_err[s]), 32'(op == 3'd7));
    d0 = rsp_data[s];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      cmd_valid[s] = (h % 2 == 0);
      cmd_op[s]    = 3'd0;
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid[s]), 32'd1);
      chk("bp_data", rsp_data[s], d0);
      chk("bp_err", 32'(rsp_err[s]), 32'(op == 3'd7));
      chk("bp_cmd_ready", 32'(cmd_ready[s]), 32'd0);
    end
    @(posedge clk); #1;
    cmd_valid[s] = 1'b0;
    rsp_ready[s] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[s] = 1'b0;
    @(negedge clk);
    chk("rsp_drop", 32'(rsp_valid[s]), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready[s]), 32'd1);
  endtask

  logic [2:0]  t2_op  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [31:0] t2_exp [6] = '{32'h000000B4, 32'h00000030, 32'h000000FC,
                              32'h000000CC, 32'hFFFFFF33, 32'h000000F0};

  initial begin
    rst = 2'b11; cmd_valid = 2'b00; rsp_ready = 2'b00;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    chk("rst_alu_fn", 32'(alu_fn[0]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_data", rsp_data[0], 32'd0);
    chk("rst_op_count", 32'(opc0), 32'd0);
    rst = 2'b00;
    mdl_on = 1'b1;
    @(negedge clk);
    chk("ready_after_rst0", 32'(cmd_ready[0]), 32'd1);
    chk("ready_after_rst1", 32'(cmd_ready[1]), 32'd1);

    // ADD wrap
    do_cmd(0, 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0);
    chk("t1_op_count", 32'(opc0), 32'd1);

    // remaining legal opcodes
    for (int i = 0; i < 6; i++)
      do_cmd(0, t2_op[i], 32'h000000F0, 32'h0000003C, t2_exp[i], 0);
    chk("t2_op_count", 32'(opc0), 32'd7);

    // illegal opcode leaves ALU inputs alone
    do_cmd(0, 3'd7, 32'h12345678, 32'hDEADBEEF, 32'h00000000, 0);
    chk("t3_alu_fn", 32'(alu_fn[0]), 32'b101010);
    chk("t3_alu_a", alu_a[0], 32'h000000F0);
    chk("t3_op_count", 32'(opc0), 32'd7);

    // backpressure
    do_cmd(0, 3'd3, 32'hA5A50000, 32'h00005A5A, 32'hA5A55A5A, 5);
    chk("t4_op_count", 32'(opc0), 32'd8);

    // reset mid-WAIT on the latency-3 instance
    @(posedge clk); #1;
    cmd_valid[1] = 1'b1; cmd_op[1] = 3'd0; cmd_a[1] = 32'd10; cmd_b[1] = 32'd20;
    @(negedge clk);
    chk("t5_accept", 32'(cmd_ready[1]), 32'd1);
    @(posedge clk); #1;             // E0
    cmd_valid[1] = 1'b0;
    @(posedge clk); #1;             // E1
    @(posedge clk); #1;             // E2, in WAIT
    rst[1] = 1'b1;
    @(posedge clk); #1;
    chk("t5_cmd_ready", 32'(cmd_ready[1]), 32'd0);
    chk("t5_alu_fn", 32'(alu_fn[1]), 32'd0);
    chk("t5_alu_a", alu_a[1], 32'd0);
    chk("t5_alu_b", alu_b[1], 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("t5_rsp_data", rsp_data[1], 32'd0);
    chk("t5_rsp_err", 32'(rsp_err[1]), 32'd0);
    chk("t5_op_count", 32'(opc1), 32'd0);
    rst[1] = 1'b0;
    @(negedge clk);
    chk("t5_ready_after", 32'(cmd_ready[1]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(rsp_valid[1]), 32'd0);
    end
    do_cmd(1, 3'd0, 32'd2, 32'd3, 32'd5, 0);

    // counter wrap with CNT_WIDTH=4
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("t6_cnt_clear", 32'(opc1), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      do_cmd(1, 3'd0, 32'(i), 32'd100, 32'(i + 100), 0);
      chk("t6_op_count", 32'(opc1), 32'(i % 16));
      if (i == 5 || i == 15) begin
        do_cmd(1, 3'd7, 32'(i), 32'd1, 32'd0, 0);
        chk("t6_err_no_count", 32'(opc1), 32'(i));
      end
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
